// File: rtl/lsu_dmem_ctrl_if.sv
// Request, response and data-memory port bundle for lsu_dmem_ctrl.
// slave = LSU side, master = core / memory environment side.
interface lsu_dmem_ctrl_if #(
  parameter int DMEM_ADDR_WIDTH = 12
);
  logic                       req_valid_i;
  logic                       req_ready_o;
  logic                       req_we_i;
  logic [2:0]                 req_funct3_i;
  logic [31:0]                req_addr_i;
  logic [31:0]                req_wdata_i;
  logic [4:0]                 req_rd_i;
  logic                       rsp_valid_o;
  logic                       rsp_ready_i;
  logic [4:0]                 rsp_rd_o;
  logic [31:0]                rsp_rdata_o;
  logic                       err_o;
  logic [31:0]                err_addr_o;
  logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_o;
  logic                       dmem_rd_en_o;
  logic                       dmem_wr_en_o;
  logic [1:0]                 dmem_sz_o;
  logic [31:0]                dmem_din_o;
  logic [31:0]                dmem_dout_i;

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i,
    input  req_addr_i, req_wdata_i, req_rd_i,
    input  rsp_ready_i, dmem_dout_i,
    output req_ready_o, rsp_valid_o, rsp_rd_o,
    output rsp_rdata_o, err_o, err_addr_o,
    output dmem_addr_o, dmem_rd_en_o, dmem_wr_en_o,
    output dmem_sz_o, dmem_din_o
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i,
    output req_addr_i, req_wdata_i, req_rd_i,
    output rsp_ready_i, dmem_dout_i,
    input  req_ready_o, rsp_valid_o, rsp_rd_o,
    input  rsp_rdata_o, err_o, err_addr_o,
    input  dmem_addr_o, dmem_rd_en_o, dmem_wr_en_o,
    input  dmem_sz_o, dmem_din_o
  );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// LSU data-memory controller: IDLE/ACCESS/RESP load/store sequencer.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module lsu_dmem_ctrl #(
  parameter int DMEM_ADDR_WIDTH = 12
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  lsu_dmem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e state_q;

  logic                       we_q;
  logic [2:0]                 f3_q;
  logic [4:0]                 rd_q;
  logic                       req_ready_q;
  logic                       rsp_valid_q;
  logic [31:0]                rdata_q;
  logic [DMEM_ADDR_WIDTH-1:0] addr_q;
  logic                       rd_en_q;
  logic                       wr_en_q;
  logic [1:0]                 sz_q;
  logic [31:0]                din_q;

  logic [1:0]  sz_d;
  logic        mis;
  logic [31:0] ext;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^bus.req_addr_i[31:DMEM_ADDR_WIDTH];

  assign sz_d = (bus.req_funct3_i[1:0] == 2'b11) ?
                2'b10 : bus.req_funct3_i[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  logic        err_q;
  logic [31:0] err_addr_q;

  assign mis = ((sz_d == 2'b01) && bus.req_addr_i[0]) ||
               ((sz_d == 2'b10) && (bus.req_addr_i[1:0] != 2'b00));
  assign bus.err_o      = err_q;
  assign bus.err_addr_o = err_addr_q;
`else
  assign mis            = 1'b0;
  assign bus.err_o      = 1'b0;
  assign bus.err_addr_o = 32'h0;
`endif

  // funct3[1] set covers W and every reserved encoding
  always_comb begin
    ext = bus.dmem_dout_i;
    unique case (1'b1)
      f3_q[1]:
        ext = bus.dmem_dout_i;
      !f3_q[1] && f3_q[0]:
        ext = f3_q[2] ?
              {16'h0, bus.dmem_dout_i[15:0]} :
              {{16{bus.dmem_dout_i[15]}}, bus.dmem_dout_i[15:0]};
      default:
        ext = f3_q[2] ?
              {24'h0, bus.dmem_dout_i[7:0]} :
              {{24{bus.dmem_dout_i[7]}}, bus.dmem_dout_i[7:0]};
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      rd_q        <= 5'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      sz_q        <= 2'b00;
      din_q       <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q       <= 1'b0;
      err_addr_q  <= 32'h0;
`endif
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid_i) begin
            we_q        <= bus.req_we_i;
            f3_q        <= bus.req_funct3_i;
            rd_q        <= bus.req_rd_i;
            req_ready_q <= 1'b0;
            if (mis) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rdata_q     <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
              err_q       <= 1'b1;
              err_addr_q  <= bus.req_addr_i;
`endif
            end else begin
              state_q <= ACCESS;
              addr_q  <= bus.req_addr_i[DMEM_ADDR_WIDTH-1:0];
              sz_q    <= sz_d;
              din_q   <= bus.req_wdata_i;
              wr_en_q <= bus.req_we_i;
              rd_en_q <= !bus.req_we_i;
            end
          end
        end
        ACCESS: begin
          if (we_q) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
          end else begin
            state_q     <= RESP;
            rdata_q     <= ext;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q       <= 1'b0;
`endif
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready_o  = req_ready_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_rd_o     = rd_q;
  assign bus.rsp_rdata_o  = rdata_q;
  assign bus.dmem_addr_o  = addr_q;
  assign bus.dmem_rd_en_o = rd_en_q;
  assign bus.dmem_wr_en_o = wr_en_q;
  assign bus.dmem_sz_o    = sz_q;
  assign bus.dmem_din_o   = din_q;
endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Bench for lsu_dmem_ctrl: byte-array data memory plus a reference
// memory image predicting every load, directed cases then random ops.
module tb_lsu_dmem_ctrl;
  logic clk_i = 1'b0;
  logic rst_ni;

  always #5 clk_i = ~clk_i;

  lsu_dmem_ctrl_if #(.DMEM_ADDR_WIDTH(12)) bus ();

  lsu_dmem_ctrl #(.DMEM_ADDR_WIDTH(12)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [7:0] seed_byte(int i);
    return 8'((i * 37 + 5) ^ (i >> 4));
  endfunction

  // data memory the DUT talks to
  logic [7:0] mem [4096];
  bit         seeded;
  logic [11:0] ma;

  assign ma = bus.dmem_addr_o;
  assign bus.dmem_dout_i = {mem[12'(ma + 12'd3)], mem[12'(ma + 12'd2)],
                            mem[12'(ma + 12'd1)], mem[ma]};

  always @(posedge clk_i) begin
    if (!seeded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= seed_byte(i);
      seeded <= 1'b1;
    end else if (bus.dmem_wr_en_o) begin
      for (int i = 0; i < 4; i++)
        if (i == 0 || (i == 1 && bus.dmem_sz_o != 2'b00) ||
            bus.dmem_sz_o == 2'b10)
          mem[12'(ma + 12'(i))] <= bus.dmem_din_o[8*i +: 8];
    end
  end

  // reference image, updated from requests only
  logic [7:0] ref_mem [4096];

  function automatic int nbytes(logic [2:0] f3);
    if (f3[1]) return 4;
    return f3[0] ? 2 : 1;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3,
                                           logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[12'(a + 32'(i))];
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready_o), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
    chk({tag, "_wr_en"}, 32'(bus.dmem_wr_en_o), 32'd0);
    chk({tag, "_rd_en"}, 32'(bus.dmem_rd_en_o), 32'd0);
    chk({tag, "_addr"}, 32'(bus.dmem_addr_o), 32'd0);
    chk({tag, "_sz"}, 32'(bus.dmem_sz_o), 32'd0);
    chk({tag, "_din"}, bus.dmem_din_o, 32'd0);
    chk({tag, "_rdata"}, bus.rsp_rdata_o, 32'd0);
    chk({tag, "_rsp_rd"}, 32'(bus.rsp_rd_o), 32'd0);
    chk({tag, "_err"}, 32'(bus.err_o), 32'd0);
    chk({tag, "_err_addr"}, bus.err_addr_o, 32'd0);
  endtask

  // present one request and complete its handshake; ends at a negedge
  task automatic send(input bit we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [4:0] rd);
    int n = 0;
    while (!bus.req_ready_o && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    chk("req_ready_wait", 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = a;
    bus.req_wdata_i  = wd;
    bus.req_rd_i     = rd;
    @(posedge clk_i);
    #1;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'($urandom);
    bus.req_funct3_i = 3'($urandom);
    bus.req_addr_i   = $urandom;
    bus.req_wdata_i  = $urandom;
    bus.req_rd_i     = 5'($urandom);
    @(negedge clk_i);
  endtask

  task automatic run_op(input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rd, input int stall);
    logic [31:0] exp;
    logic [1:0]  esz;
    bit          mis;
    esz = f3[1] ? 2'b10 : {1'b0, f3[0]};
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (esz == 2'b01 && a[0]) || (esz == 2'b10 && a[1:0] != 2'b00);
`endif
    exp = ref_load(f3, a);
    send(we, f3, a, wd, rd);
    chk("busy_ready", 32'(bus.req_ready_o), 32'd0);
    if (mis) begin
      exp = 32'h0;
      chk("trap_wr_en", 32'(bus.dmem_wr_en_o), 32'd0);
      chk("trap_rd_en", 32'(bus.dmem_rd_en_o), 32'd0);
      chk("trap_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("trap_err", 32'(bus.err_o), 32'd1);
      chk("trap_err_addr", bus.err_addr_o, a);
      chk("trap_rdata", bus.rsp_rdata_o, 32'd0);
      chk("trap_rd", 32'(bus.rsp_rd_o), 32'(rd));
    end else begin
      chk("acc_addr", 32'(bus.dmem_addr_o), 32'(a[11:0]));
      chk("acc_sz", 32'(bus.dmem_sz_o), 32'(esz));
      chk("acc_wr_en", 32'(bus.dmem_wr_en_o), 32'(we));
      chk("acc_rd_en", 32'(bus.dmem_rd_en_o), 32'(!we));
      chk("acc_valid", 32'(bus.rsp_valid_o), 32'd0);
      if (we) begin
        chk("acc_din", bus.dmem_din_o, wd);
        for (int i = 0; i < nbytes(f3); i++)
          ref_mem[12'(a + 32'(i))] = wd[8*i +: 8];
        @(negedge clk_i);
        chk("st_done_wr_en", 32'(bus.dmem_wr_en_o), 32'd0);
        chk("st_done_ready", 32'(bus.req_ready_o), 32'd1);
        chk("st_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
        return;
      end
      @(negedge clk_i);
      chk("ld_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("ld_rd", 32'(bus.rsp_rd_o), 32'(rd));
      chk("ld_rdata", bus.rsp_rdata_o, exp);
      chk("ld_err", 32'(bus.err_o), 32'd0);
      chk("ld_rd_en_off", 32'(bus.dmem_rd_en_o), 32'd0);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_i);
      chk("hold_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("hold_rdata", bus.rsp_rdata_o, exp);
      chk("hold_rd", 32'(bus.rsp_rd_o), 32'(rd));
      chk("hold_ready", 32'(bus.req_ready_o), 32'd0);
      chk("hold_en", 32'({bus.dmem_rd_en_o, bus.dmem_wr_en_o}), 32'd0);
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.rsp_ready_i = 1'b0;
    @(negedge clk_i);
    chk("rsp_done_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rsp_done_ready", 32'(bus.req_ready_o), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = seed_byte(i);
    rst_ni           = 1'b0;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = 3'b000;
    bus.req_addr_i   = 32'h0;
    bus.req_wdata_i  = 32'h0;
    bus.req_rd_i     = 5'd0;
    bus.rsp_ready_i  = 1'b0;
    repeat (2) @(negedge clk_i);
    chk_reset_outputs("por");
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_op(1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 5'd0, 0);
    run_op(1'b0, 3'b010, 32'h010, 32'h0, 5'd5, 0);
    run_op(1'b0, 3'b000, 32'h011, 32'h0, 5'd1, 0);
    run_op(1'b0, 3'b100, 32'h011, 32'h0, 5'd2, 0);
    run_op(1'b0, 3'b001, 32'h012, 32'h0, 5'd3, 0);
    run_op(1'b0, 3'b101, 32'h012, 32'h0, 5'd4, 0);
    run_op(1'b0, 3'b010, 32'h013, 32'h0, 5'd6, 0);
    run_op(1'b0, 3'b010, 32'h010, 32'h0, 5'd7, 5);
    run_op(1'b0, 3'b111, 32'h010, 32'h0, 5'd8, 1);
    run_op(1'b1, 3'b010, 32'h12345FFC, 32'hCAFEF00D, 5'd0, 0);
    run_op(1'b1, 3'b001, 32'h00000FFF, 32'h0000A55A, 5'd0, 0);
    run_op(1'b0, 3'b010, 32'h00000FFE, 32'h0, 5'd9, 0);

    // reset in the middle of a store access: no write may land
    send(1'b1, 3'b010, 32'hABCDEFFC, 32'h13579BDF, 5'd0);
    chk("rst_st_addr", 32'(bus.dmem_addr_o), 32'h0FFC);
    chk("rst_st_wr_en", 32'(bus.dmem_wr_en_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("rst_st");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_op(1'b0, 3'b010, 32'h00000FFC, 32'h0, 5'd10, 0);

    // reset while a response is pending: it is discarded
    send(1'b0, 3'b010, 32'h020, 32'h0, 5'd11);
    @(negedge clk_i);
    chk("rst_rsp_valid_pre", 32'(bus.rsp_valid_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("rst_rsp");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_rsp_idle", 32'(bus.rsp_valid_o), 32'd0);

    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      run_op(1'($urandom), 3'($urandom), a, $urandom,
             5'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
